// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core: load-use bubbles, branch flush, memory-wait freeze.
// Optional stall-cycle performance counter is built only when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int LU_STALL_CYC = 1,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_we,
    output logic        id_ex_flush,
    output logic        ex_mem_we,
    output logic [1:0]  state,
    output logic        timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        P_ADV,
        P_FREEZE,
        P_BUBBLE,
        P_BRFL
    } pat_e;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
    localparam logic [2:0] LU_LAST  = 3'(LU_STALL_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [2:0] lcnt_q, lcnt_d;
    logic       timeout_q, timeout_d;
    logic       tmo_evt;
    pat_e       pat;
    logic       lu;
    logic       mem_stall;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'h7) ? v : v + 3'd1;
    endfunction

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        lcnt_d    = lcnt_q;
        timeout_d = timeout_q;
        tmo_evt   = 1'b0;
        pat       = P_ADV;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pat     = P_FREEZE;
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else if (ex_branch_taken) begin
                    pat = P_BRFL;
                end else if (lu) begin
                    pat = P_BUBBLE;
                    if (LU_STALL_CYC > 1) begin
                        state_d = LOAD_STALL;
                        lcnt_d  = 3'd1;
                    end
                end
            end
            LOAD_STALL: begin
                if (mem_stall) begin
                    pat     = P_FREEZE;
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else if (ex_branch_taken) begin
                    pat     = P_BRFL;
                    state_d = RUN;
                end else begin
                    pat    = P_BUBBLE;
                    lcnt_d = sat_inc3(lcnt_q);
                    if (lcnt_q == LU_LAST) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // A dropped mem_req releases the freeze exactly like mem_ready.
                if (!mem_stall) begin
                    pat     = ex_branch_taken ? P_BRFL : P_ADV;
                    state_d = RUN;
                end else if (wcnt_q == WAIT_MAX) begin
                    tmo_evt   = 1'b1;
                    timeout_d = 1'b1;
                    pat       = P_ADV;
                    state_d   = RUN;
                end else begin
                    pat    = P_FREEZE;
                    wcnt_d = sat_inc8(wcnt_q);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= 8'd0;
            lcnt_q    <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            lcnt_q    <= lcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset overrides the pattern so both buffers clear while rst_n is low.
    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_we    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b0;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (pat)
                P_ADV: begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    id_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                end
                P_BUBBLE: begin
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                end
                P_BRFL: begin
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state   = state_q;
    assign timeout = timeout_q | tmo_evt;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (!pc_we && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
